// File: rtl/toy_pack.sv
// Shared constants and types for the BPU fetch reorder buffer.
package toy_pack;

  localparam int BPU_ROB_DEPTH    = 8;
  localparam int FETCH_DATA_WIDTH = 32;
  localparam int BPU_ROB_PTR_W    = $clog2(BPU_ROB_DEPTH);

  // Index plus one wrap bit in the MSB.
  typedef logic [BPU_ROB_PTR_W:0] bpu_rob_ptr_t;

endpackage

// File: rtl/toy_bpu_rob_ptr.sv
// Wrap-bit ring pointer: increments by one, clears to zero, exposes index/wrap split.
module toy_bpu_rob_ptr #(
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [PTR_W:0]   ptr_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             wrap_o
);

  logic [PTR_W:0] ptr_q;
  logic [PTR_W:0] ptr_d;

  // NOTE: ptr_d gets its hold value before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign idx_o  = ptr_q[PTR_W-1:0];
  assign wrap_o = ptr_q[PTR_W];

endmodule

// File: rtl/toy_bpu_rob_ctrl.sv
// Allocation and in-order retirement control for the BPU fetch reorder buffer.
module toy_bpu_rob_ctrl
  import toy_pack::*;
#(
  parameter int ROB_DEPTH = BPU_ROB_DEPTH,
  localparam int PTR_W    = $clog2(ROB_DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_vld,
  output logic                                req_rdy,
  output logic [PTR_W-1:0]                    req_rob_id,
  output logic [ROB_DEPTH-1:0]                icache_prealloc,
  input  logic [ROB_DEPTH-1:0]                entry_wait_0,
  input  logic [ROB_DEPTH-1:0]                entry_valid,
  input  logic [ROB_DEPTH-1:0]                entry_invalid,
  input  logic [ROB_DEPTH*FETCH_DATA_WIDTH-1:0] entry_pld,
  output logic [ROB_DEPTH-1:0]                filter_rden,
  output logic [ROB_DEPTH-1:0]                filter_bypass,
  input  logic                                fe_ctrl_flush,
  output logic                                out_vld,
  input  logic                                out_rdy,
  output logic [FETCH_DATA_WIDTH-1:0]         out_pld,
  output logic [PTR_W-1:0]                    out_rob_id,
  output logic [PTR_W:0]                      rob_cnt,
  output logic                                rob_empty,
  output logic                                rob_full
);

  localparam logic [ROB_DEPTH-1:0] LSB_ONE = {{(ROB_DEPTH-1){1'b0}}, 1'b1};

  logic [PTR_W:0]   head_ptr, tail_ptr;
  logic [PTR_W-1:0] head_idx, tail_idx;
  logic             head_wrap, tail_wrap;
  logic             alloc, head_inc;
  logic             can_retire, head_invalid, head_valid;

  toy_bpu_rob_ptr #(.PTR_W(PTR_W)) u_head (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (head_inc),
    .clr_i  (fe_ctrl_flush),
    .ptr_o  (head_ptr),
    .idx_o  (head_idx),
    .wrap_o (head_wrap)
  );

  toy_bpu_rob_ptr #(.PTR_W(PTR_W)) u_tail (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (alloc),
    .clr_i  (fe_ctrl_flush),
    .ptr_o  (tail_ptr),
    .idx_o  (tail_idx),
    .wrap_o (tail_wrap)
  );

  assign rob_empty = (head_ptr == tail_ptr);
  assign rob_full  = (head_idx == tail_idx) && (head_wrap != tail_wrap);
  assign rob_cnt   = tail_ptr - head_ptr;

  // A slot whose pre-flush icache ack is still in flight cannot be handed out again.
  assign req_rdy         = ~rob_full & ~entry_wait_0[tail_idx] & ~fe_ctrl_flush;
  assign alloc           = req_vld & req_rdy;
  assign req_rob_id      = tail_idx;
  assign icache_prealloc = alloc ? (LSB_ONE << tail_idx) : '0;

  assign can_retire   = ~rob_empty & ~fe_ctrl_flush;
  assign head_invalid = entry_invalid[head_idx];
  assign head_valid   = entry_valid[head_idx];

  // Killed heads release without a downstream handshake; out_vld never looks at out_rdy.
  assign out_vld       = can_retire & ~head_invalid & head_valid;
  assign filter_bypass = (can_retire & head_invalid) ? (LSB_ONE << head_idx) : '0;
  assign filter_rden   = (out_vld & out_rdy) ? (LSB_ONE << head_idx) : '0;
  assign head_inc      = (can_retire & head_invalid) | (out_vld & out_rdy);

  assign out_rob_id = head_idx;
  assign out_pld    = entry_pld[head_idx*FETCH_DATA_WIDTH +: FETCH_DATA_WIDTH];

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      a_retire_onehot : assert ($onehot0(filter_rden | filter_bypass));
      a_alloc_onehot  : assert ($onehot0(icache_prealloc));
    end
  end
`endif

endmodule
